// File: rtl/codma_mover_pkg.sv
// Shared state type and size-code decoding for the CODMA burst mover.
package codma_mover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ASK,
    RD_DATA,
    WR_ASK,
    WR_DATA,
    DONE
  } mover_state_t;

  localparam logic [7:0] SIZE_2W  = 8'd3;
  localparam logic [7:0] SIZE_4W  = 8'd8;
  localparam logic [7:0] SIZE_8W  = 8'd9;
  localparam logic [7:0] SIZE_16W = 8'd10;

  // Unknown codes decode to zero words so callers can flag them as illegal.
  function automatic int unsigned size_to_words(input logic [7:0] size);
    case (size)
      SIZE_2W:  return 2;
      SIZE_4W:  return 4;
      SIZE_8W:  return 8;
      SIZE_16W: return 16;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/codma_word_buffer.sv
// Word register file for the burst mover: one whole beat written per cycle,
// one whole beat read combinationally, both addressed by beat index.
module codma_word_buffer
  import codma_mover_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned IDX_W     = 3
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned WPB    = DATA_W / WORD_W;
  localparam int unsigned NBEATS = MAX_WORDS / WPB;

  // Word k of beat b is buffer word b*WPB+k.
  logic [WORD_W-1:0] r_mem [NBEATS][WPB];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < WPB; k++) begin
        r_mem[wr_idx_i][k] <= wr_data_i[k*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < WPB; k++) begin
      rd_data_o[k*WORD_W +: WORD_W] = r_mem[rd_idx_i][k];
    end
  end

endmodule

// File: rtl/codma_burst_mover.sv
// CODMA copy engine: reads one burst from src into a word buffer, then writes
// it to dst, with size validation, write backpressure and sticky errors.
module codma_burst_mover
  import codma_mover_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [7:0]        size_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              bus_read_o,
  output logic              bus_write_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_size_o,
  input  logic              bus_grant_i,
  input  logic              bus_read_valid_i,
  input  logic [DATA_W-1:0] bus_read_data_i,
  output logic              bus_write_valid_o,
  output logic [DATA_W-1:0] bus_write_data_o,
  input  logic              bus_write_ready_i,
  input  logic              bus_error_i
);

  localparam int unsigned WPB    = DATA_W / WORD_W;
  localparam int unsigned NBEATS = MAX_WORDS / WPB;
  localparam int unsigned CNT_W  = $clog2(NBEATS + 1);
  localparam int unsigned BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  mover_state_t      r_state;
  logic [CNT_W-1:0]  r_beat;
  logic [CNT_W-1:0]  r_beats;
  logic [ADDR_W-1:0] r_dst;
  logic [7:0]        r_size;
  logic              r_done;
  logic              r_error;
  logic              r_rd;
  logic              r_wr;
  logic              r_wvalid;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_bsize;

  logic              w_legal;
  logic [CNT_W-1:0]  w_start_beats;
  logic              w_last;
  logic              w_buf_wr;
  logic [BIDX_W-1:0] w_beat_idx;
  logic [DATA_W-1:0] w_buf_rd;

  always_comb begin
    int unsigned words;
    words         = size_to_words(size_i);
    w_legal       = (words != 0) && (words <= MAX_WORDS) && ((words % WPB) == 0);
    w_start_beats = CNT_W'(words / WPB);
  end

  assign w_last     = (r_beat == r_beats - CNT_W'(1));
  assign w_beat_idx = r_beat[BIDX_W-1:0];
  assign w_buf_wr   = (r_state == RD_DATA) && bus_read_valid_i && !bus_error_i;

  codma_word_buffer #(
    .WORD_W    (WORD_W),
    .DATA_W    (DATA_W),
    .MAX_WORDS (MAX_WORDS),
    .IDX_W     (BIDX_W)
  ) u_buffer (
    .clk_i     (clk_i),
    .wr_en_i   (w_buf_wr),
    .wr_idx_i  (w_beat_idx),
    .wr_data_i (bus_read_data_i),
    .rd_idx_i  (w_beat_idx),
    .rd_data_o (w_buf_rd)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_beats  <= '0;
      r_dst    <= '0;
      r_size   <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_wvalid <= 1'b0;
      r_addr   <= '0;
      r_bsize  <= '0;
    end else begin
      r_done <= 1'b0;
      // A bus error in any active bus state aborts ahead of grants and last beats.
      if ((r_state inside {RD_ASK, RD_DATA, WR_ASK, WR_DATA}) && bus_error_i) begin
        r_state  <= DONE;
        r_done   <= 1'b1;
        r_error  <= 1'b1;
        r_rd     <= 1'b0;
        r_wr     <= 1'b0;
        r_wvalid <= 1'b0;
        r_beat   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_dst   <= dst_addr_i;
              r_size  <= size_i;
              r_error <= 1'b0;
              r_beat  <= '0;
              if (w_legal) begin
                r_state <= RD_ASK;
                r_beats <= w_start_beats;
                r_rd    <= 1'b1;
                r_addr  <= src_addr_i;
                r_bsize <= size_i;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_error <= 1'b1;
              end
            end
          end
          RD_ASK: begin
            if (bus_grant_i) begin
              r_rd    <= 1'b0;
              r_state <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (bus_read_valid_i) begin
              if (w_last) begin
                r_beat  <= '0;
                r_state <= WR_ASK;
                r_wr    <= 1'b1;
                r_addr  <= r_dst;
                r_bsize <= r_size;
              end else begin
                r_beat <= r_beat + CNT_W'(1);
              end
            end
          end
          WR_ASK: begin
            if (bus_grant_i) begin
              r_wr     <= 1'b0;
              r_wvalid <= 1'b1;
              r_state  <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (bus_write_ready_i) begin
              if (w_last) begin
                r_beat   <= '0;
                r_wvalid <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end else begin
                r_beat <= r_beat + CNT_W'(1);
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o            = (r_state != IDLE);
  assign done_o            = r_done;
  assign error_o           = r_error;
  assign bus_read_o        = r_rd;
  assign bus_write_o       = r_wr;
  assign bus_addr_o        = r_addr;
  assign bus_size_o        = r_bsize;
  assign bus_write_valid_o = r_wvalid;
  // Buffer read is a mux of registers indexed by the beat counter, so it holds
  // steady for as long as the slave stalls.
  assign bus_write_data_o  = r_wvalid ? w_buf_rd : '0;

endmodule

// File: doc/codma_burst_mover.md
Name: codma_burst_mover

Overview:
- Parametrised successor to the CODMA read/write machine pair.
- One controller performs a complete copy: it reads a burst from a source address into an internal word buffer, then writes that buffer to a destination address.
- Adds configurable beat width and buffer depth, a 16-word size code, size validation, write backpressure, and sticky error reporting with a done pulse.
- Sits between the CODMA descriptor/control logic and the shared system bus master port.

Parameters:
- ADDR_W, 32, address width.
- WORD_W, 32, buffer word width.
- DATA_W, 64, bus beat width. Must be a multiple of WORD_W. WPB = DATA_W/WORD_W words per beat.
- MAX_WORDS, 16, buffer depth in words. Power of two, at least WPB.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_n_i  in  1  reset; synchronous, active-low.
- start_i  in  1  copy request; sampled only in IDLE.
- src_addr_i  in  ADDR_W  source address, latched on an accepted start.
- dst_addr_i  in  ADDR_W  destination address, latched on an accepted start.
- size_i  in  8  size code, latched on an accepted start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at the end of every accepted copy.
- error_o  out  1  sticky error flag; cleared by the next accepted start.
- bus_read_o  out  1  read request.
- bus_write_o  out  1  write request.
- bus_addr_o  out  ADDR_W  request address.
- bus_size_o  out  8  request size code.
- bus_grant_i  in  1  grant for the pending request.
- bus_read_valid_i  in  1  read beat valid.
- bus_read_data_i  in  DATA_W  read beat data.
- bus_write_valid_o  out  1  write beat valid.
- bus_write_data_o  out  DATA_W  write beat data.
- bus_write_ready_i  in  1  slave accepts the current write beat.
- bus_error_i  in  1  bus error.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; buffer contents don't-care.
- Size decode (package function): 3→2 words, 8→4 words, 9→8 words, 10→16 words.
  - The size is illegal if the code is not in that list, if words > MAX_WORDS, or if words is not a multiple of WPB.
  - BEATS = words/WPB.
- IDLE
  - An accepted start latches src_addr_i, dst_addr_i and size_i, and clears error_o.
  - Legal size → RD_ASK. Illegal size → DONE with error_o set; no bus activity is generated.
  - start_i is ignored in every other state.
- RD_ASK
  - bus_read_o=1, bus_addr_o=src, bus_size_o=size, all registered.
  - Hold these until bus_grant_i is sampled high, then go to RD_DATA. bus_read_o drops in the first RD_DATA cycle.
  - Minimum latency: start accepted in cycle N; bus_read_o high in cycle N+1.
- RD_DATA
  - Each cycle with bus_read_valid_i=1 is exactly one new beat. No duplicate-data filtering.
  - Word k of the beat, bits [k*WORD_W +: WORD_W], goes to buffer[beat*WPB+k].
  - The beat counter increments per beat. After beat BEATS-1 is captured: counter cleared, → WR_ASK.
  - read_valid in any other state is ignored; beats beyond BEATS are never captured.
- WR_ASK
  - bus_write_o=1, bus_addr_o=dst, bus_size_o=size.
  - Hold until bus_grant_i is sampled high, then → WR_DATA.
- WR_DATA
  - bus_write_valid_o=1, bus_write_data_o = buffer words beat*WPB .. beat*WPB+WPB-1, with the lowest index in the LSBs.
  - Data is stable while ready=0.
  - The counter advances only on valid&ready. The last accepted beat → DONE, and bus_write_valid_o drops the next cycle.
- DONE
  - done_o=1 for exactly one cycle; busy_o=1; → IDLE.
- Error
  - bus_error_i=1 in RD_ASK, RD_DATA, WR_ASK or WR_DATA → DONE next cycle.
  - On that transition: error_o set, and all bus request/valid outputs deasserted.
  - An error takes priority over a simultaneous grant or last beat.
- Counter: width $clog2(MAX_WORDS/WPB + 1); never wraps, since it is cleared on leaving a data state.
- Reset asserted mid-operation: on the next edge, state returns to IDLE and all outputs go to 0. No completion pulse is produced.

Decomposition:
- Package codma_mover_pkg holds:
  - mover_state_t enum: IDLE, RD_ASK, RD_DATA, WR_ASK, WR_DATA, DONE.
  - SIZE_2W/4W/8W/16W constants (3/8/9/10).
  - Function size_to_words(size) returning 0 for an unknown code.
- One sub-module, codma_word_buffer: MAX_WORDS × WORD_W register file.
  - Write side is one beat (WPB words) per cycle at a beat index.
  - Read side is a combinational beat read.

Test Plan:
- Copy, size=8, DATA_W=64, src=0x1000, dst=0x2000, grant after 2 cycles, read beats 0xB_A then 0xD_C.
  - Write beats: 0x...B_A then 0x...D_C at dst.
  - done_o pulses once; error_o=0.
- size=10 with MAX_WORDS=8 → no bus_read_o; done_o the cycle after start's successor; error_o=1.
- size=9, ready toggles 1,0,0,1,...
  - Exactly 4 beats are accepted, with data held stable while ready=0.
  - Extra read_valid pulses after the 4th read beat are ignored.
- bus_error_i during the 2nd read beat of size=9 → DONE next cycle; error_o=1; no write request issued.
- start_i pulsed while in WR_DATA → ignored; the copy completes unchanged, with one done_o pulse.
- reset_n_i low for 1 cycle during RD_DATA → all outputs 0 and IDLE at the next edge. A subsequent size=3 copy succeeds.
